// File: rtl/pe_conv_pkg.sv
// Shared helpers for the convolution processing element.
//   slice_lo : low bit of element idx in a flat vector of w-bit elements
//   clog2_c  : ceil(log2(v)) usable in constant expressions
//   sat_pw   : clamp a wide signed value to PW bits (or pass through when
//              saturation is off; the caller truncates for wrap mode)
//   ovf_pw   : 1 when a wide signed value does not fit in PW signed bits
package pe_conv_pkg;

    // Width of the intermediate used for the range check; the adder tree
    // width (PW + clog2(K+1) + 1) must not exceed it.
    localparam int SAT_W = 64;

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic int clog2_c(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_pw(
        input logic signed [SAT_W-1:0] v,
        input int                      pw,
        input bit                      sat
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (pw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat && (v > hi)) return hi;
        if (sat && (v < lo)) return lo;
        return v;
    endfunction

    function automatic logic ovf_pw(
        input logic signed [SAT_W-1:0] v,
        input int                      pw
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (pw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/pe_conv_row_window.sv
// K-tap sliding window of the feature-map stream with fill tracking.
//   clk, rst     : clock, synchronous active-high reset
//   en           : global advance (0 = hold)
//   clr          : line restart, empties the window
//   vld_in, din  : incoming feature sample
//   accept       : sample taken this cycle (en && vld_in && !clr)
//   tap0         : newest stored tap
//   taps_next    : window contents as they will be after this cycle's shift
//   win_ok       : accepted sample completes a full K-sample window
module pe_shift_window
    import pe_conv_pkg::*;
#(
    parameter int K  = 3,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 vld_in,
    input  logic [DW-1:0]        din,
    output logic                 accept,
    output logic [DW-1:0]        tap0,
    output logic [K-1:0][DW-1:0] taps_next,
    output logic                 win_ok
);

    localparam int FW = clog2_c(K + 1);
    // The oldest tap only ever feeds the products through taps_next, so it
    // is never stored: K-1 history registers (at least one, for tap0).
    localparam int HD = (K > 1) ? K - 1 : 1;

    logic [HD-1:0][DW-1:0] hist;
    logic [FW-1:0]         fill;

    assign accept = en && vld_in && !clr;
    assign tap0   = hist[0];
    // fill counts samples before the shift, so K-1 already means "full after".
    assign win_ok = accept && (fill >= FW'(K - 1));

    always_comb begin
        taps_next    = '0;
        taps_next[0] = din;
        for (int i = 1; i < K; i++) taps_next[i] = hist[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            if (clr) begin
                hist <= '0;
                fill <= '0;
            end else if (accept) begin
                hist[0] <= din;
                for (int j = 1; j < HD; j++) hist[j] <= hist[j-1];
                if (fill != FW'(K)) fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_conv_row.sv
// Convolution processing element for one row of the systolic array.
// Holds a K-sample sliding window and a stationary K-weight filter, and
// produces psum_in + dot(window, weights) two en-cycles after the sample
// that completes the window.
//   clk, rst             : clock, synchronous active-high reset
//   en                   : global advance; 0 freezes every register
//   clr                  : line restart (window, fill, valids, ovf)
//   w_load, w_in         : weight load, w[i] at bits [i*WW +: WW]
//   w_out, w_out_vld     : weight register to next PE, pulse after a load
//   if_vld_in, if_in     : feature sample in
//   if_out, if_vld_out   : newest tap and accept flag to next PE
//   psum_in              : upstream partial sum, taken with the sample
//   psum_out, psum_vld_out : result
//   ovf                  : sticky overflow, cleared by rst or clr
module pe_conv_row
    import pe_conv_pkg::*;
#(
    parameter int K   = 3,
    parameter int DW  = 8,
    parameter int WW  = 8,
    parameter int PW  = 20,
    parameter bit SAT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          w_load,
    input  logic [K*WW-1:0] w_in,
    output logic [K*WW-1:0] w_out,
    output logic          w_out_vld,
    input  logic          if_vld_in,
    input  logic [DW-1:0] if_in,
    output logic [DW-1:0] if_out,
    output logic          if_vld_out,
    input  logic [PW-1:0] psum_in,
    output logic [PW-1:0] psum_out,
    output logic          psum_vld_out,
    output logic          ovf
);

    localparam int PD     = DW + WW;
    localparam int SW     = PW + clog2_c(K + 1) + 1;
    localparam int STAGES = 2;

    if (K < 1) begin : g_bad_k
        $error("pe_conv_row: K must be at least 1");
    end
    if (PW < DW + WW) begin : g_bad_pw
        $error("pe_conv_row: PW must be at least DW+WW");
    end
    if (SW > SAT_W) begin : g_bad_sw
        $error("pe_conv_row: accumulator wider than range-check intermediate");
    end

    logic                 accept;
    logic                 win_ok;
    logic [K-1:0][DW-1:0] taps_next;
    logic [DW-1:0]        tap0;

    logic [K*WW-1:0]      wreg;
    logic [K-1:0][PD-1:0] prod_d;
    logic [K-1:0][PD-1:0] prod_q;
    logic [PW-1:0]        psum_d;
    logic [STAGES:1]      vld_pipe;

    logic signed [SW-1:0]    sum;
    logic signed [SAT_W-1:0] sum_ext;
    logic [PW-1:0]           psum_res;
    logic                    ovf_now;

    pe_shift_window #(
        .K  (K),
        .DW (DW)
    ) u_win (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .vld_in    (if_vld_in),
        .din       (if_in),
        .accept    (accept),
        .tap0      (tap0),
        .taps_next (taps_next),
        .win_ok    (win_ok)
    );

    assign if_out       = tap0;
    assign w_out        = wreg;
    assign psum_vld_out = vld_pipe[STAGES];

    // Products use the register contents before any same-cycle load, so a
    // load coinciding with an accept takes effect from the next accept.
    for (genvar i = 0; i < K; i++) begin : g_mul
        assign prod_d[i] = PD'($signed(taps_next[i])) *
                           PD'($signed(wreg[slice_lo(i, WW) +: WW]));
    end

    // Wide enough that K products plus psum can never wrap before the check.
    always_comb begin
        sum = SW'($signed(psum_d));
        for (int i = 0; i < K; i++) sum = sum + SW'($signed(prod_q[i]));
    end

    assign sum_ext  = SAT_W'(sum);
    assign psum_res = PW'(sat_pw(sum_ext, PW, SAT));
    assign ovf_now  = ovf_pw(sum_ext, PW);

    // Weight register is untouched by clr: weights are stationary per layer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wreg      <= '0;
            w_out_vld <= 1'b0;
        end else if (en) begin
            if (w_load) wreg <= w_in;
            w_out_vld <= w_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            psum_d     <= '0;
            vld_pipe   <= '0;
            if_vld_out <= 1'b0;
            psum_out   <= '0;
            ovf        <= 1'b0;
        end else if (en) begin
            // Stage 1: win_ok already implies accept, and accept is low on clr.
            if_vld_out  <= accept;
            vld_pipe[1] <= win_ok;
            if (accept) begin
                prod_q <= prod_d;
                psum_d <= psum_in;
            end
            // Stage 2: result holds whenever no new valid arrives.
            if (clr) begin
                vld_pipe[2] <= 1'b0;
                ovf         <= 1'b0;
            end else begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    psum_out <= psum_res;
                    if (ovf_now) ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_conv_row.sv
module tb_pe_conv_row;

    localparam int K  = 3;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int PW = 20;
    localparam longint MAXV = (64'sd1 <<< (PW - 1)) - 1;
    localparam longint MINV = -MAXV - 1;

    logic clk = 1'b0;
    logic rst, en, clr, w_load, if_vld_in;
    logic [K*WW-1:0] w_in;
    logic [DW-1:0]   if_in;
    logic [PW-1:0]   psum_in;

    logic [K*WW-1:0] w_out_s, w_out_w;
    logic            wv_s, wv_w, iv_s, iv_w, pv_s, pv_w, ovf_s, ovf_w;
    logic [DW-1:0]   if_out_s, if_out_w;
    logic [PW-1:0]   po_s, po_w;

    int tests = 0;
    int fails = 0;

    // Reference model state: window as a queue (newest first), weights as ints,
    // the pending exact dot product, and the expected registered outputs.
    int     win[$];
    int     wts[K];
    int     wnext[K];
    longint m_full;
    bit     m_v1, m_vld, m_ovf, m_if_vld, m_wvld;
    longint m_sat, m_wrap;

    always #5 clk = ~clk;

    pe_conv_row #(.K(K), .DW(DW), .WW(WW), .PW(PW), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .w_load(w_load), .w_in(w_in), .w_out(w_out_s), .w_out_vld(wv_s),
        .if_vld_in(if_vld_in), .if_in(if_in), .if_out(if_out_s), .if_vld_out(iv_s),
        .psum_in(psum_in), .psum_out(po_s), .psum_vld_out(pv_s), .ovf(ovf_s)
    );

    pe_conv_row #(.K(K), .DW(DW), .WW(WW), .PW(PW), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .w_load(w_load), .w_in(w_in), .w_out(w_out_w), .w_out_vld(wv_w),
        .if_vld_in(if_vld_in), .if_in(if_in), .if_out(if_out_w), .if_vld_out(iv_w),
        .psum_in(psum_in), .psum_out(po_w), .psum_vld_out(pv_w), .ovf(ovf_w)
    );

    function automatic longint clampv(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic longint wrapv(input longint v);
        longint m;
        m = v & ((64'sd1 <<< PW) - 1);
        if (m > MAXV) m = m - (64'sd1 <<< PW);
        return m;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [K*WW-1:0] ew;
        longint          eif;
        for (int i = 0; i < K; i++) ew[i*WW +: WW] = WW'(wts[i]);
        eif = (win.size() > 0) ? longint'(win[0]) : 0;
        chk("w_out_s",   longint'(w_out_s), longint'(ew));
        chk("w_out_w",   longint'(w_out_w), longint'(ew));
        chk("w_vld_s",   longint'(wv_s), longint'(m_wvld));
        chk("w_vld_w",   longint'(wv_w), longint'(m_wvld));
        chk("if_out_s",  longint'($signed(if_out_s)), eif);
        chk("if_out_w",  longint'($signed(if_out_w)), eif);
        chk("if_vld_s",  longint'(iv_s), longint'(m_if_vld));
        chk("if_vld_w",  longint'(iv_w), longint'(m_if_vld));
        chk("psum_vld_s", longint'(pv_s), longint'(m_vld));
        chk("psum_vld_w", longint'(pv_w), longint'(m_vld));
        chk("psum_s",    longint'($signed(po_s)), m_sat);
        chk("psum_w",    longint'($signed(po_w)), m_wrap);
        chk("ovf_s",     longint'(ovf_s), longint'(m_ovf));
        chk("ovf_w",     longint'(ovf_w), longint'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model by the same rules, check.
    task automatic step(input bit r, input bit e, input bit v, input int x,
                        input longint ps, input bit c, input bit wl);
        bit acc;
        rst = r; en = e; if_vld_in = v; if_in = DW'(x); psum_in = PW'(ps);
        clr = c; w_load = wl;
        for (int i = 0; i < K; i++) w_in[i*WW +: WW] = WW'(wnext[i]);
        @(posedge clk);
        if (r) begin
            win.delete();
            for (int i = 0; i < K; i++) wts[i] = 0;
            m_full = 0; m_v1 = 0; m_vld = 0; m_ovf = 0; m_if_vld = 0; m_wvld = 0;
            m_sat = 0; m_wrap = 0;
        end else if (e) begin
            acc = v && !c;
            if (c) begin
                m_vld = 0;
                m_ovf = 0;
            end else begin
                m_vld = m_v1;
                if (m_v1) begin
                    m_sat  = clampv(m_full);
                    m_wrap = wrapv(m_full);
                    if (m_full > MAXV || m_full < MINV) m_ovf = 1;
                end
            end
            m_v1 = 0;
            if (c) win.delete();
            else if (acc) begin
                win.push_front(x);
                if (win.size() > K) void'(win.pop_back());
                if (win.size() == K) begin
                    m_full = ps;
                    for (int i = 0; i < K; i++) m_full += longint'(wts[i]) * longint'(win[i]);
                    m_v1 = 1;
                end
            end
            m_if_vld = acc;
            if (wl) wts = wnext;
            m_wvld = wl;
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic feed(input int x, input longint ps);
        step(0, 1, 1, x, ps, 0, 0);
    endtask

    task automatic loadw(input int a, input int b, input int c);
        wnext[0] = a; wnext[1] = b; wnext[2] = c;
        step(0, 1, 0, 0, 0, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < K; i++) wnext[i] = 0;

        // 1. reset
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("rst_psum", longint'(po_s), 0);
        chk("rst_vld", longint'(pv_s | iv_s | wv_s), 0);
        chk("rst_ovf", longint'(ovf_s), 0);
        chk("rst_wout", longint'(w_out_s), 0);

        // 2. basic window
        loadw(1, 2, 3);
        feed(10, 100);  chk("t2_novld1", longint'(pv_s), 0);
        feed(20, 100);  chk("t2_novld2", longint'(pv_s), 0);
        feed(30, 100);
        feed(40, 0);    chk("t2_200", longint'($signed(po_s)), 200);
                        chk("t2_vld", longint'(pv_s), 1);
        idle();         chk("t2_160", longint'($signed(po_s)), 160);
        idle();         chk("t2_drop", longint'(pv_s), 0);
                        chk("t2_hold", longint'($signed(po_s)), 160);

        // 3. signed extremes
        loadw(-128, -128, -128);
        feed(127, 0); feed(127, 0); feed(127, 0);
        idle();         chk("t3_neg", longint'($signed(po_s)), -48768);
                        chk("t3_ovf", longint'(ovf_s), 0);

        // 4. overflow
        loadw(127, 127, 127);
        feed(127, 0); feed(127, 0); feed(127, 524000);
        idle();         chk("t4_sat", longint'($signed(po_s)), 524287);
                        chk("t4_wrap", longint'($signed(po_w)), -476189);
                        chk("t4_ovf", longint'(ovf_s), 1);
        idle(); idle(); chk("t4_sticky", longint'(ovf_s), 1);

        // 6. clr mid-line, sample presented with clr is dropped
        feed(1, 0); feed(2, 0);
        step(0, 1, 1, 99, 0, 1, 0);
        chk("t6_ovfclr", longint'(ovf_s), 0);
        chk("t6_ifout", longint'(if_out_s), 0);
        feed(5, 0);     chk("t6_novld1", longint'(pv_s), 0);
        feed(6, 0);     chk("t6_novld2", longint'(pv_s), 0);
        feed(7, 0);
        idle();         chk("t6_res", longint'($signed(po_s)), 2286);
                        chk("t6_vld", longint'(pv_s), 1);

        // 5. stall between samples 20 and 30; clr during the stall is ignored
        loadw(1, 2, 3);
        step(0, 1, 0, 0, 0, 1, 0);
        feed(10, 100); feed(20, 100);
        step(0, 0, 1, 55, 0, 0, 0);
        chk("t5_if_frz", longint'(if_out_s), 20);
        chk("t5_po_frz", longint'($signed(po_s)), 2286);
        step(0, 0, 1, 66, 0, 1, 0);
        chk("t5_if_frz2", longint'(if_out_s), 20);
        chk("t5_vld_frz", longint'(iv_s), 1);
        feed(30, 100);
        feed(40, 0);    chk("t5_200", longint'($signed(po_s)), 200);
                        chk("t5_vld", longint'(pv_s), 1);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit r, e, v, c, wl;
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 29) == 0);
            wl = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < K; i++) wnext[i] = int'($urandom_range(0, 255)) - 128;
            step(r, e, v, int'($urandom_range(0, 255)) - 128,
                 longint'($urandom_range(0, 1048575)) - 524288, c, wl);
        end

        // final reset
        step(1, 1, 1, 5, 5, 0, 1);
        chk("end_psum", longint'(po_w), 0);
        chk("end_ovf", longint'(ovf_w), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
